// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and
// the baud divisor helper used by both the RX and TX sides.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = 3;

  // Receiver state encoding; RX_PARITY_BIT is only visited when parity is built in
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    RX_START_BIT  = 3'd1,
    RX_DATA_BITS  = 3'd2,
    RX_PARITY_BIT = 3'd3,
    RX_STOP_BIT   = 3'd4,
    CLEANUP       = 3'd5
  } rx_state_e;

  // Clock cycles per UART bit for a given system clock and baud rate
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RESET_VAL sets the value both flops take during reset (idle-high line -> 1).
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Metastability chain: first flop may go metastable, second resolves it
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta     <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
// The serial line is synchronized, then sampled at each bit centre.
// Optional parity bit (and o_RX_Parity_Err) when UART_RX_PARITY_EN is defined;
// PARITY_ODD selects odd (1) or even (0) parity in that build.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD   = 1'b0
`endif
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_RX_Parity_Err
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  // Last cycle of a full bit period, and the start-bit centre
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

  rx_state_e                   state;
  logic [CNT_W-1:0]            clk_cnt;
  logic [UART_IDX_W-1:0]       bit_idx;
  logic [UART_DATA_BITS-1:0]   rx_data;
  logic                        rx_s;

`ifdef UART_RX_PARITY_EN
  logic rx_par;
  logic parity_ok_c;

  // Received parity bit must equal the XOR of the data, inverted for odd parity
  assign parity_ok_c = (rx_par == ((^rx_data) ^ PARITY_ODD));
`endif

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .async_in (i_RX_Serial),
    .sync_out (rx_s)
  );

  // Receive FSM: bit timing, data capture and the output strobes
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      rx_data        <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Byte      <= 8'h00;
      o_RX_Active    <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_par          <= 1'b0;
      o_RX_Parity_Err <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_RX_Parity_Err <= 1'b0;
`endif

      case (state)
        IDLE: begin
          clk_cnt     <= '0;
          bit_idx     <= '0;
          o_RX_Active <= 1'b0;
          if (!rx_s) begin
            state       <= RX_START_BIT;
            o_RX_Active <= 1'b1;
          end
        end

        // Re-check the line at the start-bit centre to reject glitches
        RX_START_BIT: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state <= RX_DATA_BITS;
            end else begin
              state       <= IDLE;
              o_RX_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // One full bit period from the previous centre lands on the next centre
        RX_DATA_BITS: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt          <= '0;
            rx_data[bit_idx] <= rx_s;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= RX_PARITY_BIT;
`else
              state   <= RX_STOP_BIT;
`endif
            end else begin
              bit_idx <= bit_idx + UART_IDX_W'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        RX_PARITY_BIT: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            rx_par  <= rx_s;
            state   <= RX_STOP_BIT;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif

        // Stop bit decides between a good byte and an error strobe
        RX_STOP_BIT: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt     <= '0;
            state       <= CLEANUP;
            o_RX_Active <= 1'b0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (parity_ok_c) begin
                o_RX_Byte <= rx_data;
                o_RX_DV   <= 1'b1;
              end else begin
                o_RX_Parity_Err <= 1'b1;
              end
`else
              o_RX_Byte <= rx_data;
              o_RX_DV   <= 1'b1;
`endif
            end else begin
              o_RX_Frame_Err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // Hold off new frames until the line has returned high (break / stuck-low)
        CLEANUP: begin
          clk_cnt     <= '0;
          bit_idx     <= '0;
          o_RX_Active <= 1'b0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          o_RX_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx with CLKS_PER_BIT=8.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CPB        = 8;
  localparam bit          PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  // 2 sync flops + detect + half start bit, then whole bits up to the stop-bit centre
  localparam int FRAME_LAT = 4 + int'((CPB - 1) / 2) + int'((FRAME_BITS - 1) * CPB);

  localparam int OUT_OK = 0;
  localparam int OUT_FE = 1;
  localparam int OUT_PE = 2;

  logic       i_Clock;
  logic       i_Reset;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_RX_Frame_Err;
`ifdef UART_RX_PARITY_EN
  logic       o_RX_Parity_Err;
  logic       par_val;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] dv_q[$];
  int         fe_cnt      = 0;
  int         pe_cnt      = 0;
  int         dv_cyc      = 0;
  int         overlap_cnt = 0;
  int         dv_long_cnt = 0;
  logic       prev_dv     = 1'b0;
  logic [7:0] exp_last    = 8'h00;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD   (PARITY_ODD)
`endif
  ) dut (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_RX_Serial    (i_RX_Serial),
    .o_RX_DV        (o_RX_DV),
    .o_RX_Byte      (o_RX_Byte),
    .o_RX_Active    (o_RX_Active),
    .o_RX_Frame_Err (o_RX_Frame_Err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_RX_Parity_Err(o_RX_Parity_Err)
`endif
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge i_Clock) begin
    if (prev_dv) chk("active_after_dv", 32'(o_RX_Active), 32'(0));
    if (o_RX_DV) begin
      dv_q.push_back(o_RX_Byte);
      dv_cyc = cyc;
    end
    if (o_RX_Frame_Err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (o_RX_Parity_Err) pe_cnt++;
`endif
    if (o_RX_DV && o_RX_Frame_Err) overlap_cnt++;
    if (o_RX_DV && prev_dv) dv_long_cnt++;
    prev_dv = o_RX_DV;
  end

  // Reference: what a frame should produce, from its stop and parity bits alone
  function automatic int model_outcome(input logic [7:0] d, input logic stop);
    if (!stop) return OUT_FE;
`ifdef UART_RX_PARITY_EN
    begin
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      ones += int'(par_val);
      if ((ones % 2) != (PARITY_ODD ? 1 : 0)) return OUT_PE;
    end
`endif
    return OUT_OK;
  endfunction

  task automatic drive_bit(input logic b);
    i_RX_Serial = b;
    repeat (CPB) @(posedge i_Clock);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      if (i == 3) chk("active_mid", 32'(o_RX_Active), 32'(1));
    end
`ifdef UART_RX_PARITY_EN
    drive_bit(par_val);
`endif
    drive_bit(stop);
  endtask

  task automatic frame_and_check(input logic [7:0] d, input logic stop);
    int dv0, fe0, pe0, c0, outcome;
    dv0 = dv_q.size();
    fe0 = fe_cnt;
    pe0 = pe_cnt;
    c0  = cyc;
    outcome = model_outcome(d, stop);
    send_frame(d, stop);
    if (outcome == OUT_OK) exp_last = d;
    chk("dv_count", 32'(dv_q.size() - dv0), 32'((outcome == OUT_OK) ? 1 : 0));
    if (outcome == OUT_OK && dv_q.size() > dv0) begin
      chk("dv_byte", 32'(dv_q[$]), 32'(d));
      chk("dv_latency", 32'(dv_cyc - c0), 32'(FRAME_LAT));
    end
    chk("frame_err_count", 32'(fe_cnt - fe0), 32'((outcome == OUT_FE) ? 1 : 0));
`ifdef UART_RX_PARITY_EN
    chk("parity_err_count", 32'(pe_cnt - pe0), 32'((outcome == OUT_PE) ? 1 : 0));
`else
    chk("parity_err_count", 32'(pe_cnt - pe0), 32'(0));
`endif
    chk("byte_hold", 32'(o_RX_Byte), 32'(exp_last));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dv0, fe0, stuck;
    logic [7:0] d;
    logic       stop;

    i_RX_Serial = 1'b1;
    i_Reset     = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_val     = 1'b0;
`endif
    repeat (3) @(posedge i_Clock);
    #1;
    chk("rst_dv",     32'(o_RX_DV),        32'(0));
    chk("rst_byte",   32'(o_RX_Byte),      32'(0));
    chk("rst_active", 32'(o_RX_Active),    32'(0));
    chk("rst_ferr",   32'(o_RX_Frame_Err), 32'(0));
    i_Reset = 1'b0;
    idle_bits(2);

    // Single clean frame
`ifdef UART_RX_PARITY_EN
    par_val = (^8'hA5) ^ PARITY_ODD;
`endif
    frame_and_check(8'hA5, 1'b1);
    idle_bits(1);

    // Back-to-back frames, no idle between stop and next start
`ifdef UART_RX_PARITY_EN
    par_val = 1'b0 ^ PARITY_ODD;
`endif
    frame_and_check(8'h00, 1'b1);
`ifdef UART_RX_PARITY_EN
    par_val = 1'b0 ^ PARITY_ODD;
`endif
    frame_and_check(8'hFF, 1'b1);
    idle_bits(1);

    // Short low glitch must not start a frame
    dv0 = dv_q.size();
    fe0 = fe_cnt;
    i_RX_Serial = 1'b0;
    repeat (2) @(posedge i_Clock);
    #1;
    i_RX_Serial = 1'b1;
    idle_bits(2);
    chk("glitch_dv",     32'(dv_q.size() - dv0), 32'(0));
    chk("glitch_ferr",   32'(fe_cnt - fe0),      32'(0));
    chk("glitch_active", 32'(o_RX_Active),       32'(0));
`ifdef UART_RX_PARITY_EN
    par_val = (^8'h3C) ^ PARITY_ODD;
`endif
    frame_and_check(8'h3C, 1'b1);
    idle_bits(1);

    // Bad stop bit, then line stuck low: receiver must wait in cleanup
`ifdef UART_RX_PARITY_EN
    par_val = (^8'h55) ^ PARITY_ODD;
`endif
    frame_and_check(8'h55, 1'b0);
    dv0   = dv_q.size();
    stuck = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_Clock);
      #1;
      if (o_RX_Active) stuck++;
    end
    chk("cleanup_no_active", 32'(stuck), 32'(0));
    chk("cleanup_no_dv", 32'(dv_q.size() - dv0), 32'(0));
    i_RX_Serial = 1'b1;
    idle_bits(2);

    // Reset in the middle of data bit 4 aborts the frame
    dv0 = dv_q.size();
    d   = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    i_RX_Serial = d[4];
    repeat (4) @(posedge i_Clock);
    #2;
    i_Reset = 1'b1;
    #1;
    chk("midrst_dv",     32'(o_RX_DV),        32'(0));
    chk("midrst_byte",   32'(o_RX_Byte),      32'(0));
    chk("midrst_active", 32'(o_RX_Active),    32'(0));
    chk("midrst_ferr",   32'(o_RX_Frame_Err), 32'(0));
    exp_last = 8'h00;
    i_RX_Serial = 1'b1;
    repeat (4) @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;
    chk("midrst_no_dv", 32'(dv_q.size() - dv0), 32'(0));
    idle_bits(2);
`ifdef UART_RX_PARITY_EN
    par_val = (^8'h81) ^ PARITY_ODD;
`endif
    frame_and_check(8'h81, 1'b1);
    idle_bits(1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1
    par_val = 1'b0;
    frame_and_check(8'h07, 1'b1);
    idle_bits(1);
    par_val = 1'b1;
    frame_and_check(8'h07, 1'b1);
    idle_bits(1);
`endif

    // Random frames with occasional bad stop bits and random gaps
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      par_val = (^d) ^ PARITY_ODD ^ ($urandom_range(0, 3) == 0);
`endif
      frame_and_check(d, stop);
      if (!stop) begin
        i_RX_Serial = 1'b1;
        idle_bits(1);
      end
      idle_bits($urandom_range(0, 2));
    end

    idle_bits(1);
    chk("dv_ferr_overlap", 32'(overlap_cnt), 32'(0));
    chk("dv_single_cycle", 32'(dv_long_cnt), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
